// File: rtl/pts_pkg.sv
// Shared types and frame sizing for the parallel-to-serial transmitter.
// PTS_PARITY_EN adds one even-parity bit to the end of each frame.
package pts_pkg;

  typedef enum logic {PTS_IDLE, PTS_SHIFT} pts_state_t;

  function automatic int frame_len(input int width);
`ifdef PTS_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_w(input int width);
    return $clog2(frame_len(width));
  endfunction

endpackage

// File: rtl/pts_word_buffer.sv
// Single-entry holding register between the upstream handshake and the shifter.
// Each entry is one full frame: the data bits, plus the parity bit when PTS_PARITY_EN is set.
module pts_word_buffer
  import pts_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int EW = frame_len(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [EW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [EW-1:0] out_data,
  input  logic          pop
);

  logic          full;
  logic [EW-1:0] data;
  logic          push;
  logic          full_nxt;

  assign push     = in_valid && in_ready;
  assign full_nxt = (full && !pop) || push;

  // Ready is registered from the next-state flag, so it never depends on serial_ready in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_nxt;
      in_ready <= !full_nxt;
      if (push) data <= in_data;
    end
  end

  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/parallel_to_serial_fc.sv
// LSB-first word serializer with valid/ready on both sides and a one-word holding register.
// PTS_PARITY_EN appends an even-parity bit to each frame, and that bit carries serial_last.
module parallel_to_serial_fc
  import pts_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [WIDTH-1:0] parallel_data,
  output logic             parallel_ready,
  input  logic             serial_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  output logic             busy
);

  localparam int FL = frame_len(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  pts_state_t    state;
  logic [FL-1:0] sr;
  logic [CW-1:0] cnt;
  logic [FL-1:0] word_ext;
  logic [FL-1:0] hr_data;
  logic          hr_full;
  logic          sr_full;
  logic          in_xfer;
  logic          out_xfer;
  logic          last_xfer;
  logic          load_direct;
  logic          hr_push_valid;
  logic          hr_pop;

`ifdef PTS_PARITY_EN
  assign word_ext = {^parallel_data, parallel_data};
`else
  assign word_ext = parallel_data;
`endif

  assign sr_full   = (state == PTS_SHIFT);
  assign in_xfer   = parallel_valid && parallel_ready;
  assign out_xfer  = sr_full && serial_ready;
  assign last_xfer = out_xfer && serial_last;

  // A word bypasses HR when the shifter is empty or empties on this same edge.
  assign load_direct   = in_xfer && (!sr_full || (last_xfer && !hr_full));
  assign hr_push_valid = parallel_valid && sr_full && !last_xfer;
  assign hr_pop        = last_xfer && hr_full;

  pts_word_buffer #(.WIDTH(WIDTH)) u_hr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hr_push_valid),
    .in_data   (word_ext),
    .in_ready  (parallel_ready),
    .out_valid (hr_full),
    .out_data  (hr_data),
    .pop       (hr_pop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PTS_IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        PTS_IDLE: begin
          if (load_direct) begin
            sr    <= word_ext;
            cnt   <= '0;
            state <= PTS_SHIFT;
          end
        end
        PTS_SHIFT: begin
          if (out_xfer) begin
            if (serial_last) begin
              if (hr_full) begin
                sr  <= hr_data;
                cnt <= '0;
              end else if (load_direct) begin
                sr  <= word_ext;
                cnt <= '0;
              end else begin
                sr    <= '0;
                cnt   <= '0;
                state <= PTS_IDLE;
              end
            end else begin
              sr  <= {1'b0, sr[FL-1:1]};
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= PTS_IDLE;
      endcase
    end
  end

  assign serial_valid = sr_full;
  assign serial_data  = sr[0];
  assign serial_last  = sr_full && (cnt == CW'(FL - 1));
  assign busy         = sr_full || hr_full;

endmodule

// File: doc/parallel_to_serial_fc.md
Name: parallel_to_serial_fc

Overview:
- Transmit-side counterpart of the serial-to-parallel deserializer.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per transfer, LSB first.
- The serial side has its own valid/ready flow control.
- A one-word holding register lets a continuous stream run with no idle cycle between words. Feeds serial links and the team's deserializer.

Parameters:
- WIDTH, 8, parallel word width in bits; legal values are WIDTH >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- parallel_valid  input  1  upstream word available
- parallel_data  input  WIDTH  upstream word
- parallel_ready  output  1  block can accept a word this cycle
- serial_ready  input  1  downstream accepts the current bit
- serial_valid  output  1  serial_data holds a valid bit
- serial_data  output  1  current bit
- serial_last  output  1  current bit is the last bit of its frame
- busy  output  1  shift register or holding register occupied

Behaviour:
- Reset (rst low, asynchronous):
  - Clears shift register, holding register, bit counter and both occupancy flags.
  - Output values during reset: serial_valid=0, serial_data=0, serial_last=0, busy=0, parallel_ready=0.
  - Release of reset is synchronous to clk. parallel_ready=1 on the first cycle after release.
  - Reset mid-frame drops all partial data. Nothing resumes after reset.
- Transfer definitions:
  - In-transfer: parallel_valid && parallel_ready at a posedge.
  - Out-transfer: serial_valid && serial_ready at a posedge.
- Storage and ready:
  - Two entries: the shift register (SR, with flag sr_full) and the holding register (HR, with flag hr_full).
  - parallel_ready = !hr_full. This is a registered flag with no combinational path from serial_ready.
- FSM:
  - IDLE: sr_full=0.
  - SHIFT: sr_full=1; bit counter cnt runs 0..FRAME_LEN-1.
- Loading a word:
  - In-transfer while in IDLE (HR empty): the word loads directly into SR and cnt=0; the FSM moves to SHIFT.
  - First bit appears one cycle after the accepting edge (latency 1).
- Bit transfer:
  - serial_valid = sr_full.
  - serial_data = SR[0]. On an out-transfer SR shifts right by 1 and cnt increments.
  - serial_valid holds and serial_data is stable while serial_ready=0.
- serial_last = sr_full && (cnt == FRAME_LEN-1).
- End of frame:
  - Out-transfer with serial_last and hr_full: HR moves into SR, cnt=0, hr_full clears; stay in SHIFT with no bubble.
  - Out-transfer with serial_last and !hr_full: go to IDLE. An in-transfer on the same edge loads SR directly, so there is still no bubble.
- In-transfer while in SHIFT with HR empty: the word goes to HR. This includes the last-bit edge only when HR empty and the FSM stays in SHIFT; that case is covered by the direct load above.
- Simultaneous in-transfer and last-bit out-transfer with HR full cannot occur, because ready=0 in that case.
- busy = sr_full || hr_full.
- Throughput: with serial_ready held at 1 and the upstream always valid, one bit per cycle sustained indefinitely.
- Data is never dropped or duplicated. Bit order is parallel_data[0] first through parallel_data[WIDTH-1].

Optional Feature:
- Macro: PTS_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1. After the WIDTH data bits, one even-parity bit (XOR of the word's data bits) is emitted, and it carries serial_last.
  - The parity bit is computed at word load and stored alongside SR.
- Undefined:
  - FRAME_LEN = WIDTH; serial_last is asserted on data bit WIDTH-1.
  - No parity logic is present.
- Counter width in both cases is $clog2(FRAME_LEN).

Decomposition:
- Package pts_pkg:
  - State enum pts_state_t {PTS_IDLE, PTS_SHIFT}.
  - Function frame_len(width), returning width or width+1 per the macro.
  - Function cnt_w(width) = $clog2(frame_len(width)).
- Sub-module pts_word_buffer: the single-entry holding register with in valid/ready and out valid/pop, parameterised by WIDTH (+1 parity bit under the macro).
- The top level holds SR, cnt and the FSM.

Test Plan:
- Reset then one word 8'hA5, serial_ready=1 -> bits 1,0,1,0,0,1,0,1 on consecutive cycles starting 1 cycle after accept; serial_last on the 8th bit; then IDLE with busy=0.
- Words 8'h01, 8'hFF, 8'h80 offered back-to-back, serial_ready=1 -> 24 consecutive valid bits with no gap; parallel_ready drops while HR is full.
- serial_ready toggling randomly with random words, 100 words -> loopback through the deserializer reproduces all 100 words; bit count = 800 (900 with PTS_PARITY_EN).
- serial_ready=0 for 5 cycles mid-word 8'h3C -> serial_data and cnt frozen; stream resumes with the correct next bit.
- rst asserted at bit 4 of 8'hF0 with HR full -> outputs 0 immediately (asynchronous); after release parallel_ready=1 and no stale bits are emitted.
- PTS_PARITY_EN, word 8'h07 -> 9 bits, 9th bit=1 with serial_last; word 8'h03 -> parity bit 0.
